dmem_result_streamer: RTL

//  Reader for the result words the core writes into data memory (element1..element8 region).
//  On start, reads NUM_WORDS consecutive words via a 1-cycle-latency read port, then serialises them LSB-byte-first over 8N1 UART TX.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/uart_tx_byte.sv | 67 ++++++
 rtl/dmem_result_streamer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core-side definitions: data width, UART frame length and the result streamer state encoding.
package riscv_pkg;

  localparam int XLEN            = 32;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    CSUM,
    FIN
  } streamer_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for one byte; owns the baud and bit counters.
// ready is high when idle and during the final cycle of the stop bit, so loads there chain frames without a gap.
module uart_tx_byte
  import riscv_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  logic              active;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              bit_end;
  logic              frame_end;

  assign bit_end   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign frame_end = bit_end && (bit_cnt == 4'(UART_FRAME_BITS - 1));
  assign ready     = !active || frame_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (load && ready) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= data;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (frame_end) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

  // Line level is decoded from the counters, so an async reset forces it high at once.
  always_comb begin
    tx = 1'b1;
    if (active) begin
      if (bit_cnt == 4'd0) begin
        tx = 1'b0;
      end else if (bit_cnt <= 4'd8) begin
        tx = shreg[3'(bit_cnt - 4'd1)];
      end
    end
  end

endmodule

// File: rtl/dmem_result_streamer.sv
// Reads NUM_WORDS result words from data memory and streams them LSB byte first over 8N1 UART.
// Define DMEM_STREAM_CSUM_EN to append one XOR checksum byte after the data bytes.
module dmem_result_streamer
  import riscv_pkg::*;
#(
  parameter int              NUM_WORDS    = 8,
  parameter logic [XLEN-1:0] BASE_ADDR    = '0,
  parameter int              CLKS_PER_BIT = 868
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            mem_rd_en,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int WORD_W = $clog2(NUM_WORDS + 1);

  streamer_state_t   state, state_nxt;
  logic [WORD_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [1:0]        byte_nxt;
  logic [XLEN-1:0]   word_buf;
  logic              last_word;
  logic              uart_load;
  logic              uart_ready;
  logic [7:0]        uart_data;

  assign last_word = (word_idx == WORD_W'(NUM_WORDS - 1));
  assign byte_nxt  = byte_idx + 2'd1;
  assign mem_addr  = BASE_ADDR + {{(XLEN - WORD_W - 2){1'b0}}, word_idx, 2'b00};

`ifdef DMEM_STREAM_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (state == IDLE && start) begin
      csum_q <= '0;
    end else if (state == CAPT || (state == SEND && uart_ready && byte_idx != 2'd3)) begin
      csum_q <= csum_q ^ uart_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      word_idx <= '0;
      byte_idx <= '0;
      word_buf <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        CAPT: begin
          word_buf <= mem_rdata;
          byte_idx <= '0;
        end
        SEND: begin
          if (uart_ready) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_nxt;
            end else if (!last_word) begin
              word_idx <= word_idx + WORD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte 0 is loaded straight from the read port in CAPT so the first start bit lines up with SEND.
  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    uart_load = 1'b0;
    uart_data = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = READ;
        end
      end
      READ: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: begin
        busy      = 1'b1;
        uart_load = 1'b1;
        uart_data = mem_rdata[7:0];
        state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (uart_ready) begin
          if (byte_idx != 2'd3) begin
            uart_load = 1'b1;
            uart_data = word_buf[{byte_nxt, 3'b000} +: 8];
          end else if (!last_word) begin
            state_nxt = READ;
          end else begin
`ifdef DMEM_STREAM_CSUM_EN
            uart_load = 1'b1;
            uart_data = csum_q;
            state_nxt = CSUM;
`else
            state_nxt = FIN;
`endif
          end
        end
      end
`ifdef DMEM_STREAM_CSUM_EN
      CSUM: begin
        busy = 1'b1;
        if (uart_ready) begin
          state_nxt = FIN;
        end
      end
`endif
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .load (uart_load),
    .data (uart_data),
    .tx   (tx),
    .ready(uart_ready)
  );

endmodule
